// File: rtl/shift_iter.sv
// Iterative shift/mask unit: SLL, SRL, SRA or a word of n leading ones.
// It shifts at most STEP bit positions per BUSY cycle, with valid/ready on both sides.
module shift_iter #(
  parameter int STEP = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic [31:0] operand,
  input  logic [5:0]  count,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [1:0]  dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both 1.
  // The producer holds its payload stable while valid is 1 and ready is 0.
  // in_ready depends only on state. out_valid and result come straight from registers.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRA  = 2'b10;
  localparam logic [1:0] OP_LEAD = 2'b11;
  localparam logic [5:0] STEP_C  = 6'(STEP);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_acc;
  logic [5:0]  r_rem;
  logic        r_fill;
  logic        r_left;

  logic        w_accept;
  logic [5:0]  w_cnt_eff;
  logic [5:0]  w_k;
  logic [5:0]  w_rem_nxt;
  logic [31:0] w_fill_mask;
  logic [31:0] w_acc_step;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_acc;
  assign dbg_state = r_state;

  assign w_accept  = in_ready & in_valid & ~flush;

  // LEAD_ONES saturates at 32. Shifts use only the low five count bits.
  assign w_cnt_eff = (op == OP_LEAD) ? ((count > 6'd32) ? 6'd32 : count)
                                     : {1'b0, count[4:0]};

  assign w_k         = (r_rem < STEP_C) ? r_rem : STEP_C;
  assign w_rem_nxt   = r_rem - w_k;
  assign w_fill_mask = r_fill ? ~(32'hFFFF_FFFF >> w_k) : 32'h0;
  // The left shift always fills with 0, so it needs no mask.
  assign w_acc_step  = r_left ? (r_acc << w_k) : ((r_acc >> w_k) | w_fill_mask);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = BUSY;
      BUSY: begin
        if (flush)                  w_next = IDLE;
        else if (w_rem_nxt == 6'd0) w_next = DONE;
      end
      DONE: if (out_ready || flush) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_acc   <= 32'h0;
      r_rem   <= 6'd0;
      r_fill  <= 1'b0;
      r_left  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_acc  <= (op == OP_LEAD) ? 32'h0 : operand;
        r_rem  <= w_cnt_eff;
        r_left <= (op == OP_SLL);
        r_fill <= (op == OP_LEAD) | ((op == OP_SRA) & operand[31]);
      end else if (r_state == BUSY && !flush) begin
        r_acc <= w_acc_step;
        r_rem <= w_rem_nxt;
      end
    end
  end

endmodule
